// File: rtl/xfer_pkg.sv
// Shared types and widths for the host-side transfer sequencer.
package xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GS_REQ  = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_STREAM  = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam int unsigned XFER_BURST_LEN = 1024;
  localparam int unsigned XFER_DATA_W    = 32;
  localparam int unsigned XFER_GS_W      = 8;
  localparam int unsigned XFER_WORDS_W   = 11;

endpackage

// File: rtl/xfer_seq_timer.sv
// Loadable up-counter with a terminal-count flag; shared by the query
// timeout and the retry backoff interval.
module xfer_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/xfer_host_sequencer.sv
// Host-side write sequencer: queries free-buffer count, retries with backoff,
// then streams one burst of words from the upstream source onto the host bus.
module xfer_host_sequencer
  import xfer_pkg::*;
#(
  parameter int unsigned BURST_LEN  = XFER_BURST_LEN,
  parameter int unsigned GS_TIMEOUT = 64,
  parameter int unsigned RETRY_GAP  = 16,
  parameter int unsigned MAX_RETRY  = 8
) (
  input  logic                    clock_host,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [XFER_DATA_W-1:0]  src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    host_select,
  output logic                    hwrite_enable,
  output logic [XFER_DATA_W-1:0]  hostdata_out,
  output logic                    hostdata_oe,
  output logic                    gs_select,
  output logic                    gs_write_enable,
  input  logic [XFER_GS_W-1:0]    gs_out,
  input  logic                    gs_out_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [XFER_WORDS_W-1:0] words_sent
);

  localparam int unsigned TMR_MAX = (GS_TIMEOUT > RETRY_GAP) ? GS_TIMEOUT : RETRY_GAP;
  localparam int unsigned TW      = $clog2(TMR_MAX) + 1;
  localparam int unsigned RW      = $clog2(MAX_RETRY) + 1;

  state_e                  state_q, state_d;
  logic [RW-1:0]           retry_q, retry_d, retry_inc;
  logic [XFER_WORDS_W-1:0] words_q, words_d, words_inc;
  logic [XFER_DATA_W-1:0]  data_q, data_d;
  logic                    req_ready_q, req_ready_d;
  logic                    src_ready_q, src_ready_d;
  logic                    wr_q, wr_d;
  logic                    gs_q, gs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0]           tmr_term;

  assign retry_inc = retry_q + RW'(1);
  assign words_inc = words_q + XFER_WORDS_W'(1);

  // Timer restarts from zero on every state change; only GS_REQ and BACKOFF count.
  assign tmr_load = (state_d != state_q);
  assign tmr_en   = (state_q == ST_GS_REQ) || (state_q == ST_BACKOFF);
  assign tmr_term = (state_q == ST_BACKOFF) ? TW'(RETRY_GAP - 1) : TW'(GS_TIMEOUT - 1);

  xfer_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clock_host),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .term_i     (tmr_term),
    .tc_o       (tmr_tc)
  );

  // Next-state and next-output logic; level outputs follow the next state so
  // every output is registered alongside the state.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    words_d   = words_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = ST_GS_REQ;
          retry_d = '0;
          words_d = '0;
        end
      end
      ST_GS_REQ: begin
        // An answer in the same cycle as timeout expiry takes precedence.
        if (gs_out_enable) begin
          if (gs_out != '0) begin
            state_d = ST_STREAM;
          end else begin
            retry_d = retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = ST_BACKOFF;
            end
          end
        end else if (tmr_tc) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (tmr_tc) begin
          state_d = ST_GS_REQ;
        end
      end
      ST_STREAM: begin
        if (src_valid && src_ready_q) begin
          data_d  = src_data;
          wr_d    = 1'b1;
          words_d = words_inc;
          if (words_inc == XFER_WORDS_W'(BURST_LEN)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    src_ready_d = (state_d == ST_STREAM);
    gs_d        = (state_d == ST_GS_REQ);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clock_host) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      retry_q     <= '0;
      words_q     <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      src_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      gs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      words_q     <= words_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      src_ready_q <= src_ready_d;
      wr_q        <= wr_d;
      gs_q        <= gs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign src_ready       = src_ready_q;
  assign host_select     = wr_q;
  assign hwrite_enable   = wr_q;
  assign hostdata_oe     = wr_q;
  assign hostdata_out    = data_q;
  assign gs_select       = gs_q;
  assign gs_write_enable = gs_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign words_sent      = words_q;

endmodule

// File: tb/tb_xfer_host_sequencer.sv
// Scoreboard bench for xfer_host_sequencer: the driver queues expected bus
// words and completion events, a negedge monitor pops and compares them.
module tb_xfer_host_sequencer;

  localparam int unsigned BURST = 1024;
  localparam int unsigned TMO   = 64;
  localparam int unsigned GAP   = 16;
  localparam int unsigned MAXR  = 8;
  localparam int unsigned LIMIT = 6000;

  logic        clock_host = 1'b0;
  logic        reset      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_ready;
  logic [31:0] src_data   = '0;
  logic        src_valid  = 1'b0;
  logic        src_ready;
  logic        host_select;
  logic        hwrite_enable;
  logic [31:0] hostdata_out;
  logic        hostdata_oe;
  logic        gs_select;
  logic        gs_write_enable;
  logic [7:0]  gs_out        = '0;
  logic        gs_out_enable = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_sent;

  xfer_host_sequencer #(
    .BURST_LEN  (BURST),
    .GS_TIMEOUT (TMO),
    .RETRY_GAP  (GAP),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clock_host      (clock_host),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .host_select     (host_select),
    .hwrite_enable   (hwrite_enable),
    .hostdata_out    (hostdata_out),
    .hostdata_oe     (hostdata_oe),
    .gs_select       (gs_select),
    .gs_write_enable (gs_write_enable),
    .gs_out          (gs_out),
    .gs_out_enable   (gs_out_enable),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .words_sent      (words_sent)
  );

  always #5 clock_host = ~clock_host;

  typedef struct { logic [31:0] data; int unsigned due; } wexp_t;
  typedef struct { bit is_err; logic [10:0] words; } eexp_t;

  wexp_t       wq[$];
  eexp_t       eq[$];
  logic [7:0]  gs_ans[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  bit          mon_en = 1'b0;
  wexp_t       mon_w;
  eexp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock_host) cyc <= cyc + 1;

  // Monitor: bus writes and completion events against the scoreboard queues.
  always @(negedge clock_host) begin
    if (mon_en) begin
      if (host_select || hwrite_enable || hostdata_oe) begin
        check("write_strobes", {29'd0, host_select, hwrite_enable, hostdata_oe}, 32'd7);
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, expected no write", hostdata_out, cyc);
        end else begin
          mon_w = wq.pop_front();
          check("write_cycle", cyc, mon_w.due);
          check("write_data", hostdata_out, mon_w.data);
        end
      end else if (wq.size() > 0 && wq[0].due <= cyc) begin
        mon_w = wq.pop_front();
        check("write_missing", {31'd0, hwrite_enable}, 32'd1);
      end
      if (done || err) begin
        n_cmp++;
        if (eq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got done=%0b err=%0b, expected none", done, err);
        end else begin
          mon_e = eq.pop_front();
          check("event_err", {31'd0, err}, {31'd0, mon_e.is_err});
          check("event_done", {31'd0, done}, {31'd0, !mon_e.is_err});
          check("event_words", {21'd0, words_sent}, {21'd0, mon_e.words});
          check("event_req_ready", {31'd0, req_ready}, 32'd1);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_src_ready"}, {31'd0, src_ready}, 32'd0);
    check({tag, "_strobes"}, {29'd0, host_select, hwrite_enable, hostdata_oe}, 32'd0);
    check({tag, "_gs"}, {30'd0, gs_select, gs_write_enable}, 32'd0);
    check({tag, "_words"}, {21'd0, words_sent}, 32'd0);
    check({tag, "_done_err"}, {30'd0, done, err}, 32'd0);
  endtask

  // One request: answers from gs_ans on the resp-th cycle of each query phase,
  // source valid except every bubble-th cycle, optional reset after abort_at words.
  task automatic run_txn(input string tag, input int unsigned bubble, input int unsigned resp,
                         input logic [31:0] base, input int unsigned exp_phases,
                         input int unsigned exp_gaps, input bit exp_stream,
                         input int unsigned abort_at);
    int unsigned qcyc = 0, nph = 0, ngap = 0, gapc = 0, sent = 0, k = 0;
    bit inq = 1'b0, answered = 1'b0, seen_q = 1'b0, ended = 1'b0;
    wexp_t w;
    eexp_t e;
    if (abort_at == 0) begin
      e.is_err = !exp_stream;
      e.words  = exp_stream ? 11'(BURST) : 11'd0;
      eq.push_back(e);
    end
    @(negedge clock_host);
    req_valid = 1'b1;
    @(negedge clock_host);
    req_valid = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      gs_out_enable = 1'b0;
      gs_out        = '0;
      if (gs_select) begin
        if (!inq) begin
          inq = 1'b1; qcyc = 0; answered = 1'b0; nph++;
          if (seen_q) begin
            ngap++;
            check({tag, "_backoff_len"}, gapc, GAP);
          end
        end
        qcyc++;
        if (gs_ans.size() > 0 && qcyc == resp) begin
          gs_out_enable = 1'b1;
          gs_out        = gs_ans.pop_front();
          answered      = 1'b1;
        end
      end else begin
        if (inq) begin
          inq = 1'b0; seen_q = 1'b1; gapc = 0;
          check({tag, "_query_len"}, qcyc, answered ? resp : TMO);
        end
        gapc++;
      end
      if (abort_at != 0 && sent == abort_at) begin
        reset = 1'b0; src_valid = 1'b0; ended = 1'b1;
        break;
      end
      src_valid = (bubble == 0) || ((k % bubble) != bubble - 1);
      k++;
      src_data = base + sent;
      if (src_valid && src_ready) begin
        w.data = src_data;
        w.due  = cyc + 1;
        wq.push_back(w);
        sent++;
      end
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge clock_host);
    end
    src_valid     = 1'b0;
    gs_out_enable = 1'b0;
    if (!ended) check({tag, "_terminated"}, {31'd0, busy}, 32'd0);
    @(negedge clock_host);
    if (abort_at != 0) begin
      check_reset_state({tag, "_rst"});
      reset = 1'b1;
    end else begin
      check({tag, "_idle_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_idle_pulse_end"}, {29'd0, busy, done, err}, 32'd0);
      check({tag, "_words_hold"}, {21'd0, words_sent}, exp_stream ? BURST : 32'd0);
    end
    check({tag, "_words_left"}, wq.size(), 32'd0);
    check({tag, "_events_left"}, eq.size(), 32'd0);
    check({tag, "_answers_left"}, gs_ans.size(), 32'd0);
    check({tag, "_phases"}, nph, exp_phases);
    check({tag, "_gaps"}, ngap, exp_gaps);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock_host);
    check_reset_state("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    gs_ans = '{8'h04};
    run_txn("nominal", 0, 4, 32'h0000_0000, 1, 0, 1'b1, 0);

    gs_ans = '{8'h04};
    run_txn("bubble", 3, 2, 32'hA500_0000, 1, 0, 1'b1, 0);

    gs_ans = '{8'h00, 8'h00, 8'h01};
    run_txn("retry_ok", 0, 2, 32'h1000_0000, 3, 2, 1'b1, 0);

    gs_ans = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn("retry_exh", 0, 2, 32'h5000_0000, 8, 7, 1'b0, 0);

    gs_ans = {};
    run_txn("timeout", 0, 1, 32'h6000_0000, 1, 0, 1'b0, 0);

    gs_ans = '{8'h10};
    run_txn("tmo_edge", 0, 64, 32'h2000_0000, 1, 0, 1'b1, 0);

    gs_ans = '{8'h04};
    run_txn("abort", 0, 4, 32'h3000_0000, 1, 0, 1'b1, 500);

    gs_ans = '{8'h02};
    run_txn("after_reset", 0, 3, 32'h4000_0000, 1, 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xfer_host_sequencer.md
Name: xfer_host_sequencer

Overview:
Host-side write controller for the transfer buffer. On an upstream burst request it issues the general-setup query (gs_select/gs_write_enable) and waits for gs_out_enable. If gs_out reports free buffers, it streams BURST_LEN 32-bit words from an upstream valid/ready source onto the host bus (host_select, hwrite_enable, driven data). Query timeout, retry with backoff, and completion/error status are handled internally, so host logic only sees request/done.

Parameters:
BURST_LEN, 1024, words written per accepted request (power of two, 2..1024)
GS_TIMEOUT, 64, cycles to wait for gs_out_enable before abort
RETRY_GAP, 16, idle cycles between a zero-buffer answer and re-query
MAX_RETRY, 8, zero-buffer answers tolerated before abort

Ports:
clock_host  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request one burst
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
src_data  in  32  upstream write word
src_valid  in  1  src_data valid
src_ready  out  1  sequencer accepts word this cycle
host_select  out  1  host bus select to buffer
hwrite_enable  out  1  host write strobe
hostdata_out  out  32  data for tri-state host bus
hostdata_oe  out  1  enable for hostdata_out onto hostdata_inout
gs_select  out  1  general-setup select
gs_write_enable  out  1  general-setup write query
gs_out  in  8  free-buffer count from buffer
gs_out_enable  in  1  gs_out valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, burst complete
err  out  1  one-cycle pulse, timeout or retries exhausted
words_sent  out  11  words written in current/last burst

Behaviour:
- All outputs registered. When reset is sampled low, the next edge forces state IDLE and every output to 0 except req_ready=1, and clears all counters. Applies mid-burst too; partial bursts are not resumed.
- States: IDLE, GS_REQ, BACKOFF, STREAM, FINISH.
- IDLE: req_ready=1. On accept, clear words_sent, retry_cnt and timer, then go to GS_REQ. req_valid is ignored in every other state.
- GS_REQ: gs_select=gs_write_enable=1 every cycle; timer increments.
  - gs_out_enable=1 and gs_out!=0: go to STREAM. gs_* drop on the next edge.
  - gs_out_enable=1 and gs_out==0: retry_cnt++. If the new retry_cnt==MAX_RETRY, pulse err and go to IDLE. Otherwise go to BACKOFF.
  - Timer reaches GS_TIMEOUT-1 without gs_out_enable: pulse err and go to IDLE.
  - gs_out_enable in the same cycle as timeout expiry: gs_out_enable wins.
- BACKOFF: all bus outputs 0. After exactly RETRY_GAP cycles, go to GS_REQ with the timer cleared.
- STREAM: src_ready=1.
  - Each cycle with src_valid=1, the next edge registers hostdata_out=src_data and host_select=hwrite_enable=hostdata_oe=1, and increments words_sent. Latency is 1 cycle from source handshake to bus.
  - Each cycle with src_valid=0, the next edge drives host_select=hwrite_enable=hostdata_oe=0 (bubble). hostdata_out holds its value.
  - When the handshake that makes words_sent==BURST_LEN occurs, src_ready drops on that edge and the state moves to FINISH. No extra word is accepted.
- FINISH: bus strobes return to 0; done=1 for one cycle; then IDLE. words_sent holds until the next accept.
- gs_out_enable outside GS_REQ is ignored.
- busy is registered together with the state.
- Width: words_sent is 11 bits, so BURST_LEN=1024 is representable. The retry and timer counters use clog2 of their limit plus 1.

Decomposition:
- Package xfer_pkg holds:
  - state enum
  - default BURST_LEN
  - host bus data width (32)
  - gs_out width (8)
- One sub-module, xfer_seq_timer: a loadable up-counter with a terminal flag. It is shared between GS_TIMEOUT and RETRY_GAP counting, and cleared on every state entry.

Test Plan:
- Nominal: reset low 2 cycles. Accept request; gs_out_enable=1, gs_out=8'h04 three cycles after entering GS_REQ. Source streams 0..1023 continuously. Required: 1024 consecutive hwrite_enable cycles with hostdata_out 0..1023 in order, done pulse, words_sent=1024, req_ready=1 next cycle.
- Source bubbles: src_valid low every third cycle. Required: strobes low exactly in the cycles following bubbles, no duplicate or lost words, done after the 1024th word.
- Zero buffers then success: gs_out=0 twice, then 8'h01. Required: two BACKOFF windows of exactly 16 cycles each, three query phases, then a normal stream.
- Retry exhaustion: gs_out=0 on all 8 answers. Required: err pulse, no host_select ever asserted, IDLE afterward.
- Timeout: gs_out_enable never asserted. Required: err after 64 GS_REQ cycles. Also assert gs_out_enable on cycle 64: STREAM taken, no err.
- Reset mid-burst: reset low at word 500. Required: next edge gives all strobes 0, words_sent=0, req_ready=1. A new request then runs a full 1024-word burst.
